// File: rtl/accel_spi_sequencer.sv
// SPI mode-3 sequencer for a 3-axis accelerometer: one CTRL_REG1 write after reset
// (or on request), then periodic 6-byte burst reads latched into accel_x/y/z.
module accel_spi_sequencer #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned POLL_PERIOD = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_req,
   input  logic        SDO,
   output logic        SDI,
   output logic        SPC,
   output logic        CS,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic        sample_valid,
   output logic        busy
);
   localparam int unsigned TW         = $clog2(POLL_PERIOD + 1);
   localparam logic [55:0] CFG_FRAME  = {8'h20, 8'h47, 40'h0};
   localparam logic [55:0] READ_FRAME = {8'hE8, 48'h0};

   typedef enum logic [2:0] {RESET_WAIT, CFG, POLL_WAIT, READ, LATCH} state_t;
   typedef enum logic [1:0] {PH_LEAD, PH_LOW, PH_HIGH, PH_TAIL} phase_t;

   state_t          state;
   phase_t          phase;
   logic [7:0]      div_cnt;
   logic [5:0]      bit_cnt;
   logic [TW-1:0]   timer;
   logic [55:0]     tx;
   logic [47:0]     rx;
   logic            pend;
   logic            div_end;
   logic            last_bit;
   logic            cfg_now;
   logic            poll_done;

   always_comb begin
      div_end   = (div_cnt == 8'(CLK_DIV - 1));
      last_bit  = (state == READ) ? (bit_cnt == 6'd55) : (bit_cnt == 6'd15);
      cfg_now   = pend | cfg_req;
      poll_done = (timer == TW'(POLL_PERIOD));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RESET_WAIT;
         phase        <= PH_LEAD;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         timer        <= '0;
         tx           <= '0;
         rx           <= '0;
         pend         <= 1'b0;
         CS           <= 1'b1;
         SPC          <= 1'b1;
         SDI          <= 1'b0;
         busy         <= 1'b0;
         sample_valid <= 1'b0;
         accel_x      <= '0;
         accel_y      <= '0;
         accel_z      <= '0;
      end else begin
         sample_valid <= 1'b0;
         pend         <= pend | cfg_req;
         case (state)
            RESET_WAIT: begin
               if (timer == TW'(15)) begin
                  state   <= CFG;
                  tx      <= CFG_FRAME;
                  pend    <= 1'b0;
                  CS      <= 1'b0;
                  busy    <= 1'b1;
                  phase   <= PH_LEAD;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  timer   <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            POLL_WAIT: begin
               // timer stops at POLL_PERIOD because expiry always leaves this state
               if (cfg_now || poll_done) begin
                  CS      <= 1'b0;
                  busy    <= 1'b1;
                  phase   <= PH_LEAD;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  timer   <= '0;
                  if (cfg_now) begin
                     state <= CFG;
                     tx    <= CFG_FRAME;
                     pend  <= 1'b0;
                  end else begin
                     state <= READ;
                     tx    <= READ_FRAME;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            CFG, READ: begin
               div_cnt <= div_end ? '0 : div_cnt + 8'd1;
               if (div_end) begin
                  case (phase)
                     PH_LEAD: begin
                        SPC   <= 1'b0;
                        SDI   <= tx[55];
                        tx    <= {tx[54:0], 1'b0};
                        phase <= PH_LOW;
                     end
                     PH_LOW: begin
                        SPC   <= 1'b1;
                        rx    <= {rx[46:0], SDO};
                        phase <= PH_HIGH;
                     end
                     PH_HIGH: begin
                        if (last_bit) begin
                           CS    <= 1'b1;
                           busy  <= 1'b0;
                           SDI   <= 1'b0;
                           phase <= PH_TAIL;
                        end else begin
                           SPC     <= 1'b0;
                           SDI     <= tx[55];
                           tx      <= {tx[54:0], 1'b0};
                           bit_cnt <= bit_cnt + 6'd1;
                           phase   <= PH_LOW;
                        end
                     end
                     PH_TAIL: begin
                        // CS has been high one half-period: guarantees the inter-frame gap
                        state <= (state == READ) ? LATCH : POLL_WAIT;
                        timer <= '0;
                     end
                  endcase
               end
            end
            LATCH: begin
               accel_x      <= {rx[39:32], rx[47:40]};
               accel_y      <= {rx[23:16], rx[31:24]};
               accel_z      <= {rx[7:0],   rx[15:8]};
               sample_valid <= 1'b1;
               state        <= POLL_WAIT;
               timer        <= '0;
            end
            default: state <= RESET_WAIT;
         endcase
      end
   end
endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Bench: two sequencers (CLK_DIV=2/POLL=16 and CLK_DIV=1/POLL=20) against an SPI slave
// model that observes the bus frame by frame and predicts bytes, timing and samples.
module tb_accel_spi_sequencer;
   logic        clk;
   logic [1:0]  rst_n, cfg_req, sdo, sdi, spc, cs, busy, sv;
   logic [15:0] ax [2];
   logic [15:0] ay [2];
   logic [15:0] az [2];
   logic [47:0] seen [2];
   logic [47:0] prev_resp [2];
   bit          prev_read [2];
   int          n_pass, n_fail, n_total;

   accel_spi_sequencer #(.CLK_DIV(2), .POLL_PERIOD(16)) u_dut0 (
      .clk(clk), .rst(rst_n[0]), .cfg_req(cfg_req[0]), .SDO(sdo[0]), .SDI(sdi[0]),
      .SPC(spc[0]), .CS(cs[0]), .accel_x(ax[0]), .accel_y(ay[0]), .accel_z(az[0]),
      .sample_valid(sv[0]), .busy(busy[0]));

   accel_spi_sequencer #(.CLK_DIV(1), .POLL_PERIOD(20)) u_dut1 (
      .clk(clk), .rst(rst_n[1]), .cfg_req(cfg_req[1]), .SDO(sdo[1]), .SDI(sdi[1]),
      .SPC(spc[1]), .CS(cs[1]), .accel_x(ax[1]), .accel_y(ay[1]), .accel_z(az[1]),
      .sample_valid(sv[1]), .busy(busy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] rnd48();
      return 48'({$urandom(), $urandom()});
   endfunction

   task automatic rst_chk(input int i);
      chk("rst_cs", 64'(cs[i]), 64'(1'b1));
      chk("rst_spc", 64'(spc[i]), 64'(1'b1));
      chk("rst_sdi", 64'(sdi[i]), 64'(1'b0));
      chk("rst_busy", 64'(busy[i]), 64'(1'b0));
      chk("rst_sample_valid", 64'(sv[i]), 64'(1'b0));
      chk("rst_accel", 64'({ax[i], ay[i], az[i]}), 64'(0));
   endtask

   // Assert reset (effects must be immediate), release, then CS must stay high 15 cycles.
   task automatic rst_seq(input int i);
      int viol;
      rst_n[i] = 1'b0;
      #1;
      rst_chk(i);
      @(negedge clk);
      rst_n[i] = 1'b1;
      prev_read[i] = 1'b0;
      seen[i] = '0;
      viol = 0;
      repeat (15) begin
         @(negedge clk);
         if (cs[i] !== 1'b1) viol++;
      end
      chk("reset_wait_hold", 64'(viol), 64'(0));
   endtask

   task automatic wait_fall(input int i, input int maxc, input int pulse_at,
                            output int gap, output int svn, output int viol);
      gap = 0; svn = 0; viol = 0;
      do begin
         @(negedge clk);
         gap++;
         cfg_req[i] = (gap == pulse_at);
         if (cs[i] === 1'b1 && (spc[i] !== 1'b1 || sdi[i] !== 1'b0 || busy[i] !== 1'b0)) viol++;
         if (sv[i] === 1'b1) begin
            svn++;
            seen[i] = {ax[i], ay[i], az[i]};
         end else if ({ax[i], ay[i], az[i]} !== seen[i]) viol++;
      end while (cs[i] !== 1'b0 && gap < maxc);
      cfg_req[i] = 1'b0;
   endtask

   task automatic run_txn(input int i, input int div, input logic [55:0] frame,
                          input int pb1, input int pb2, input int abort_bit,
                          output logic [55:0] mosi, output int nbits, output int viol);
      int run, falls, guard;
      logic ps, psdi;
      mosi = '0; nbits = 0; viol = 0; falls = 0; run = 1; ps = 1'b1; guard = 0;
      psdi = sdi[i];
      if (spc[i] !== 1'b1 || busy[i] !== 1'b1 || sdi[i] !== 1'b0) viol++;
      forever begin
         @(negedge clk);
         guard++;
         cfg_req[i] = 1'b0;
         if (cs[i] !== 1'b0) begin
            if (!(ps && run == div && spc[i] === 1'b1)) viol++;
            break;
         end
         if (guard > 2 * div * 60 + 8) begin
            viol++;
            break;
         end
         if (busy[i] !== 1'b1 || sv[i] !== 1'b0 || {ax[i], ay[i], az[i]} !== seen[i]) viol++;
         if (spc[i] !== ps) begin
            if (run != div) viol++;
            run = 1;
            ps = spc[i];
            if (ps) begin
               if (sdi[i] !== psdi) viol++;
               nbits++;
               mosi = {mosi[54:0], sdi[i]};
               if (nbits == pb1 || nbits == pb2) cfg_req[i] = 1'b1;
            end else begin
               if (falls < 56) sdo[i] = frame[55 - falls];
               falls++;
               if (falls - 1 == abort_bit) break;
            end
         end else begin
            run++;
            if (sdi[i] !== psdi) viol++;
         end
         psdi = sdi[i];
      end
   endtask

   // One frame: idle gap (with sample check for the previous read), then the frame itself.
   task automatic step(input int i, input int div, input bit rd, input logic [47:0] resp,
                       input int gmin, input int gmax, input int pulse_at,
                       input int pb1, input int pb2, input int abort_bit, output int gap);
      int svn, viol, nb;
      logic [55:0] mosi;
      logic [7:0] b [6];
      wait_fall(i, gmax + 4, pulse_at, gap, svn, viol);
      chk("cs_fall_seen", 64'(cs[i]), 64'(1'b0));
      chk($sformatf("gap_%0d_within_%0d_%0d", gap, gmin, gmax), 64'(gap >= gmin && gap <= gmax), 64'(1));
      chk("idle_bus", 64'(viol), 64'(0));
      chk("sample_valid_pulses", 64'(svn), 64'(prev_read[i] ? 1 : 0));
      if (prev_read[i]) begin
         for (int k = 0; k < 6; k++) b[k] = prev_resp[i][47 - 8 * k -: 8];
         chk("accel_x", 64'(seen[i][47:32]), 64'({b[1], b[0]}));
         chk("accel_y", 64'(seen[i][31:16]), 64'({b[3], b[2]}));
         chk("accel_z", 64'(seen[i][15:0]),  64'({b[5], b[4]}));
      end
      run_txn(i, div, {8'($urandom()), resp}, pb1, pb2, abort_bit, mosi, nb, viol);
      if (abort_bit < 0) begin
         chk("spc_pulses", 64'(nb), 64'(rd ? 56 : 16));
         chk("sdi_bytes", 64'(mosi), rd ? 64'({8'hE8, 48'h0}) : 64'h2047);
         chk("frame_timing", 64'(viol), 64'(0));
         prev_read[i] = rd;
         prev_resp[i] = resp;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, g_cr, g_rr;
      n_pass = 0; n_fail = 0; n_total = 0;
      rst_n = '0; cfg_req = '0; sdo = '0;
      repeat (2) @(negedge clk);

      rst_seq(0);
      step(0, 2, 1'b0, rnd48(), 1, 1, 0, 0, 0, -1, g);
      step(0, 2, 1'b1, 48'h0180_FF7F_0000, 16, 22, 0, 0, 0, -1, g_cr);
      step(0, 2, 1'b1, rnd48(), 16, 22, 0, 10, 30, -1, g);
      chk("directed_x", 64'(seen[0][47:32]), 64'h8001);
      chk("directed_y", 64'(seen[0][31:16]), 64'h7FFF);
      chk("directed_z", 64'(seen[0][15:0]),  64'h0000);
      step(0, 2, 1'b0, rnd48(), 2, 6, 0, 0, 0, -1, g);
      step(0, 2, 1'b1, rnd48(), 16, 22, 0, 0, 0, -1, g);
      chk("cfg_to_read_gap", 64'(g), 64'(g_cr));
      step(0, 2, 1'b1, rnd48(), 16, 22, 0, 0, 0, -1, g_rr);
      step(0, 2, 1'b0, rnd48(), g_rr, g_rr, g_rr - 1, 0, 0, -1, g);
      step(0, 2, 1'b1, rnd48(), 16, 22, 0, 0, 0, -1, g);
      chk("read_after_coincident_cfg", 64'(g), 64'(g_cr));
      step(0, 2, 1'b1, rnd48(), 16, 22, 0, 0, 0, 20, g);
      rst_seq(0);
      step(0, 2, 1'b0, rnd48(), 1, 1, 0, 0, 0, -1, g);
      step(0, 2, 1'b1, rnd48(), 16, 22, 0, 0, 0, -1, g);
      step(0, 2, 1'b1, rnd48(), 16, 22, 0, 0, 0, -1, g);
      rst_n[0] = 1'b0;

      rst_seq(1);
      step(1, 1, 1'b0, rnd48(), 1, 1, 0, 0, 0, -1, g);
      for (int n = 0; n < 4; n++) step(1, 1, 1'b1, rnd48(), 20, 25, 0, 0, 0, -1, g);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/accel_spi_sequencer.md
ACCEL_SPI_SEQUENCER -- requirements
Module: accel_spi_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SPC half-period (legal range 1..255).
REQ-002 SHALL have parameter POLL_PERIOD, default 100000: clk cycles from the end of one read transaction to the start of the next (minimum 16).
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_req, input, 1: 1-cycle pulse requesting re-run of the configuration write.
REQ-006 SHALL have port SDO, input, 1: serial data from the accelerometer.
REQ-007 SHALL have port SDI, output, 1: serial data to the accelerometer.
REQ-008 SHALL have port SPC, output, 1: SPI clock, mode 3 (idles high).
REQ-009 SHALL have port CS, output, 1: active-low chip select.
REQ-010 SHALL have ports accel_x, accel_y, accel_z, output, 16 each: last sample, signed, {H,L} bytes.
REQ-011 SHALL have port sample_valid, output, 1: 1-cycle pulse when accel_x/y/z update.
REQ-012 SHALL have port busy, output, 1: high while CS is low.

Function
REQ-013 SHALL implement states RESET_WAIT, CFG, POLL_WAIT, READ, LATCH.
REQ-014 RESET_WAIT: SHALL hold 16 cycles after reset release, then go to CFG.
REQ-015 CFG: SHALL issue a 2-byte write transaction 0x20, 0x47 (CTRL_REG1: 50 Hz, XYZ enabled), then go to POLL_WAIT with the timer cleared.
REQ-016 POLL_WAIT: SHALL count to POLL_PERIOD, then go to READ; a pending cfg_req SHALL go to CFG instead.
REQ-017 READ: SHALL issue a 7-byte transaction: command 0xE8 (read, auto-increment, addr 0x28), then 6 data bytes XL,XH,YL,YH,ZL,ZH.
REQ-018 LATCH: SHALL load accel_x/y/z together from the shift bytes, pulse sample_valid one cycle, then go to POLL_WAIT.
REQ-019 Transaction timing: CS falls; one half-period; then per bit MSB-first, SPC low for CLK_DIV cycles with SDI changing at the falling edge; SPC high for CLK_DIV cycles with SDO sampled on the cycle SPC rises.
REQ-020 SHALL hold CS low one half-period after the last SPC rise, raise CS, then keep CS high at least one half-period before any next transaction.
REQ-021 SDI SHALL be 0 during READ data bytes and whenever CS is high.
REQ-022 cfg_req SHALL be latched into a pending flag; a pulse arriving during a transaction SHALL NOT abort it but SHALL be served at the next POLL_WAIT entry.
REQ-023 If cfg_req and poll-timer expiry occur in the same cycle, CFG SHALL win; the read follows POLL_PERIOD later.
REQ-024 Multiple cfg_req pulses before service SHALL collapse into one CFG.
REQ-025 accel_x/y/z SHALL be unchanged except in LATCH; a transaction never partially updates them.
REQ-026 Poll timer SHALL saturate at POLL_PERIOD, not wrap.

Reset
REQ-027 On rst low, asynchronously: state RESET_WAIT, CS=1, SPC=1, SDI=0, busy=0, sample_valid=0, accel_x/y/z=0, pending flag=0, all counters 0.
REQ-028 Reset asserted mid-transaction SHALL immediately raise CS and SPC; no data is latched; after release the sequence restarts with CFG.

Verification
REQ-029 CLK_DIV=2, after reset: CS falls at cycle 16, 16 SPC pulses, SDI shows 0x20 then 0x47, CS rises -> busy high exactly during CS low.
REQ-030 POLL_PERIOD=16, SDO model returns 0x01,0x80,0xFF,0x7F,0x00,0x00 -> accel_x=0x8001, accel_y=0x7FFF, accel_z=0x0000, one sample_valid pulse.
REQ-031 cfg_req pulsed during READ -> READ completes and latches; next transaction is CFG (0x20,0x47), then READ.
REQ-032 cfg_req coincident with timer expiry, plus a second cfg_req before service -> exactly one CFG, then READ.
REQ-033 rst low at bit 20 of READ -> CS=1, SPC=1 same cycle; outputs 0; after release CFG precedes the first READ.
REQ-034 CLK_DIV=1 -> SPC period 2 cycles, CS-high gap >=1 cycle, data still correct.
